// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - pacman game flow: lives, level, frightened timer, ghost collisions
// Optional GAME_EXTRA_LIFE_EN: each level clear also awards one life, saturating at MAX_LIVES.
module game_state_ctrl #(
   parameter int NUM_GHOSTS   = 2,
   parameter int INIT_LIVES   = 3,
   parameter int MAX_LIVES    = 7,
   parameter int MAX_LEVEL    = 15,
   parameter int PILL_W       = 33,
   parameter int READY_TICKS  = 120,
   parameter int DEATH_TICKS  = 90,
   parameter int CLEAR_TICKS  = 90,
   parameter int FRIGHT_TICKS = 360
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    tick,
   input  logic                    start,
   input  logic                    pause,
   input  logic [5:0]              pac_x,
   input  logic [4:0]              pac_y,
   input  logic [6*NUM_GHOSTS-1:0] ghost_x,
   input  logic [5*NUM_GHOSTS-1:0] ghost_y,
   input  logic [PILL_W-1:0]       pill_count,
   input  logic                    power_pill,
   output logic                    sub_reset,
   output logic                    map_reload,
   output logic                    run_en,
   output logic                    frightened,
   output logic [NUM_GHOSTS-1:0]   ghost_eaten,
   output logic [2:0]              lives,
   output logic [3:0]              level,
   output logic [2:0]              state,
   output logic                    game_over
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_DEATH = 3'd3,
      S_CLEAR = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   localparam int TICK_MAX_RD = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
   localparam int TICK_MAX    = (TICK_MAX_RD > CLEAR_TICKS) ? TICK_MAX_RD : CLEAR_TICKS;
   localparam int CNT_W       = $clog2(TICK_MAX + 1);
   localparam int FR_W        = $clog2(FRIGHT_TICKS + 1);

   state_t                  cur_state, next_state;
   logic [CNT_W-1:0]        tick_cnt;
   logic [FR_W-1:0]         fright_cnt;
   logic                    start_q;
   logic                    start_rise;
   logic [NUM_GHOSTS-1:0]   hit, hit_q, eat;
   logic                    load_game, level_up, lose_life;
   logic                    timed_state;

   assign start_rise  = start & ~start_q;
   assign sub_reset   = (cur_state != S_PLAY);
   assign run_en      = (cur_state == S_PLAY) && !pause;
   assign game_over   = (cur_state == S_OVER);
   assign frightened  = (fright_cnt != '0);
   assign state       = cur_state;
   assign timed_state = (cur_state == S_READY) || (cur_state == S_DEATH) || (cur_state == S_CLEAR);

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
         hit[i] = (ghost_x[6*i +: 6] == pac_x) && (ghost_y[5*i +: 5] == pac_y);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cur_state <= S_IDLE;
      end else begin
         cur_state <= next_state;
      end
   end

   always_comb begin
      next_state = cur_state;
      load_game  = 1'b0;
      level_up   = 1'b0;
      lose_life  = 1'b0;
      eat        = '0;
      case (cur_state)
         S_IDLE: begin
            if (start_rise) begin
               next_state = S_READY;
               load_game  = 1'b1;
            end
         end
         S_READY: begin
            if (tick && tick_cnt == CNT_W'(READY_TICKS - 1)) next_state = S_PLAY;
         end
         S_PLAY: begin
            // level clear outranks a fatal collision in the same cycle
            if (!pause) begin
               if (pill_count == '0) begin
                  next_state = S_CLEAR;
               end else if ((|hit) && !frightened) begin
                  next_state = S_DEATH;
                  lose_life  = 1'b1;
               end else if (frightened) begin
                  eat = hit & ~hit_q;
               end
            end
         end
         S_DEATH: begin
            if (tick && tick_cnt == CNT_W'(DEATH_TICKS - 1))
               next_state = (lives == 3'd0) ? S_OVER : S_READY;
         end
         S_CLEAR: begin
            if (tick && tick_cnt == CNT_W'(CLEAR_TICKS - 1)) begin
               next_state = S_READY;
               level_up   = 1'b1;
            end
         end
         S_OVER: begin
            if (start_rise) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         start_q     <= 1'b0;
         map_reload  <= 1'b0;
         ghost_eaten <= '0;
         tick_cnt    <= '0;
         fright_cnt  <= '0;
         hit_q       <= '0;
         lives       <= 3'd0;
         level       <= 4'd0;
      end else begin
         start_q     <= start;
         map_reload  <= load_game | level_up;
         ghost_eaten <= eat;

         if (next_state != cur_state)
            tick_cnt <= '0;
         else if (tick && timed_state)
            tick_cnt <= tick_cnt + CNT_W'(1);

         // a fresh power pill restarts the timer even if it is already running
         if (next_state != S_PLAY)
            fright_cnt <= '0;
         else if (!pause && power_pill)
            fright_cnt <= FR_W'(FRIGHT_TICKS);
         else if (!pause && tick && fright_cnt != '0)
            fright_cnt <= fright_cnt - FR_W'(1);

         if (cur_state != S_PLAY)
            hit_q <= '0;
         else if (!pause)
            hit_q <= hit;

         if (load_game)
            lives <= 3'(INIT_LIVES);
         else if (lose_life && lives != 3'd0)
            lives <= lives - 3'd1;
`ifdef GAME_EXTRA_LIFE_EN
         else if (level_up && lives != 3'(MAX_LIVES))
            lives <= lives + 3'd1;
`endif

         if (load_game)
            level <= 4'd1;
         else if (level_up && level != 4'(MAX_LEVEL))
            level <= level + 4'd1;
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

   logic        CLOCK_50 = 1'b0;
   logic        reset, tick, start, pause, power_pill;
   logic [5:0]  pac_x;
   logic [4:0]  pac_y;
   logic [11:0] ghost_x;
   logic [9:0]  ghost_y;
   logic [32:0] pill_count;
   logic        sub_reset, map_reload, run_en, frightened, game_over;
   logic [1:0]  ghost_eaten;
   logic [2:0]  lives;
   logic [3:0]  level;
   logic [2:0]  state;

   int tests = 0;
   int fails = 0;
   int pulses;
   int exp_lives;

   always #5 CLOCK_50 = ~CLOCK_50;

   game_state_ctrl dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .tick        (tick),
      .start       (start),
      .pause       (pause),
      .pac_x       (pac_x),
      .pac_y       (pac_y),
      .ghost_x     (ghost_x),
      .ghost_y     (ghost_y),
      .pill_count  (pill_count),
      .power_pill  (power_pill),
      .sub_reset   (sub_reset),
      .map_reload  (map_reload),
      .run_en      (run_en),
      .frightened  (frightened),
      .ghost_eaten (ghost_eaten),
      .lives       (lives),
      .level       (level),
      .state       (state),
      .game_over   (game_over)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         cyc();
      end
   endtask

   // pacman sits at (1,1); ghosts park far away unless placed on him
   task automatic ghosts_away();
      ghost_x = {6'd20, 6'd10};
      ghost_y = {5'd20, 5'd10};
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; power_pill = 1'b0;
      pac_x = 6'd1; pac_y = 5'd1; pill_count = 33'd100;
      ghosts_away();
      cyc(); cyc();
      check("rst_state", 32'(state), 32'd0);
      check("rst_sub_reset", 32'(sub_reset), 32'd1);
      check("rst_lives", 32'(lives), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_run_en", 32'(run_en), 32'd0);
      check("rst_map_reload", 32'(map_reload), 32'd0);
      check("rst_outs", 32'({game_over, frightened, ghost_eaten}), 32'd0);

      reset = 1'b0;
      cyc();
      start = 1'b1;
      cyc();
      check("start_state", 32'(state), 32'd1);
      check("start_lives", 32'(lives), 32'd3);
      check("start_level", 32'(level), 32'd1);
      check("start_map_reload", 32'(map_reload), 32'd1);
      start = 1'b0;
      cyc();
      check("map_reload_drop", 32'(map_reload), 32'd0);
      do_ticks(119);
      check("ready_119", 32'(state), 32'd1);
      check("ready_sub_reset", 32'(sub_reset), 32'd1);
      do_ticks(1);
      check("ready_120_play", 32'(state), 32'd2);
      check("play_sub_reset", 32'(sub_reset), 32'd0);
      check("play_run_en", 32'(run_en), 32'd1);

      // ghost 1 lands on pacman with no power pill active
      ghost_x = {6'd1, 6'd10}; ghost_y = {5'd1, 5'd10};
      cyc();
      check("death_state", 32'(state), 32'd3);
      check("death_lives", 32'(lives), 32'd2);
      ghosts_away();
      do_ticks(89);
      check("death_89", 32'(state), 32'd3);
      do_ticks(1);
      check("death_90_ready", 32'(state), 32'd1);
      do_ticks(120);
      check("replay", 32'(state), 32'd2);

      power_pill = 1'b1;
      cyc();
      power_pill = 1'b0;
      check("fright_on", 32'(frightened), 32'd1);
      ghost_x = {6'd20, 6'd1}; ghost_y = {5'd20, 5'd1};
      cyc();
      check("eat_first_cycle", 32'(ghost_eaten), 32'd1);
      pulses = (ghost_eaten[0]) ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (ghost_eaten[0]) pulses++;
      end
      ghosts_away();
      cyc();
      if (ghost_eaten[0]) pulses++;
      check("eat_single_pulse", 32'(pulses), 32'd1);
      check("eat_state_play", 32'(state), 32'd2);
      check("eat_lives", 32'(lives), 32'd2);

      do_ticks(200);
      pause = 1'b1;
      do_ticks(50);
      check("pause_run_en", 32'(run_en), 32'd0);
      pause = 1'b0;
      do_ticks(159);
      check("fright_359", 32'(frightened), 32'd1);
      do_ticks(1);
      check("fright_360", 32'(frightened), 32'd0);

      // collision while paused must stay frozen until unpaused
      pause = 1'b1;
      ghost_x = {6'd20, 6'd1}; ghost_y = {5'd20, 5'd1};
      do_ticks(3);
      check("pause_state", 32'(state), 32'd2);
      check("pause_lives", 32'(lives), 32'd2);
      check("pause_run_en2", 32'(run_en), 32'd0);
      pause = 1'b0;
      cyc();
      check("unpause_death", 32'(state), 32'd3);
      check("unpause_lives", 32'(lives), 32'd1);
      ghosts_away();
      do_ticks(90);
      do_ticks(120);
      check("play_lives1", 32'(state), 32'd2);

      // pill exhaustion outranks a same-cycle collision
      pill_count = 33'd0;
      ghost_x = {6'd1, 6'd10}; ghost_y = {5'd1, 5'd10};
      cyc();
      check("clear_state", 32'(state), 32'd4);
      check("clear_lives", 32'(lives), 32'd1);
      pill_count = 33'd50;
      ghosts_away();
      do_ticks(89);
      check("clear_89", 32'(state), 32'd4);
      check("clear_level_hold", 32'(level), 32'd1);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
      exp_lives = 2;
`else
      exp_lives = 1;
`endif
      check("clear_exit_state", 32'(state), 32'd1);
      check("clear_exit_level", 32'(level), 32'd2);
      check("clear_exit_reload", 32'(map_reload), 32'd1);
      check("clear_exit_lives", 32'(lives), 32'(exp_lives));
      cyc();
      check("clear_reload_drop", 32'(map_reload), 32'd0);
      do_ticks(120);

`ifdef GAME_EXTRA_LIFE_EN
      ghost_x = {6'd1, 6'd10}; ghost_y = {5'd1, 5'd10};
      cyc();
      ghosts_away();
      do_ticks(90);
      do_ticks(120);
`endif
      ghost_x = {6'd1, 6'd10}; ghost_y = {5'd1, 5'd10};
      cyc();
      check("last_death", 32'(state), 32'd3);
      check("last_lives", 32'(lives), 32'd0);
      ghosts_away();
      do_ticks(90);
      check("over_state", 32'(state), 32'd5);
      check("over_game_over", 32'(game_over), 32'd1);
      check("over_sub_reset", 32'(sub_reset), 32'd1);
      start = 1'b1;
      cyc();
      check("over_to_idle", 32'(state), 32'd0);
      start = 1'b0;
      cyc();

      start = 1'b1;
      cyc();
      start = 1'b0;
      check("restart_lives", 32'(lives), 32'd3);
      do_ticks(120);
      ghost_x = {6'd1, 6'd10}; ghost_y = {5'd1, 5'd10};
      cyc();
      check("restart_death", 32'(state), 32'd3);
      ghosts_away();
      do_ticks(10);
      reset = 1'b1;
      #2;
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_lives", 32'(lives), 32'd0);
      check("async_rst_level", 32'(level), 32'd0);
      check("async_rst_sub_reset", 32'(sub_reset), 32'd1);
      cyc();
      reset = 1'b0;
      cyc();
      check("post_rst_idle", 32'(state), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
